seg7_scroll_ctrl: RTL and testbench
===================================

Name: seg7_scroll_ctrl

Overview:
- Message scroller and sequencer for the six DE1-SoC HEX displays.
- Accepts a character message (hex digits plus the letters L, i, t and blank) over a valid/ready stream and stores it in a small buffer.
- Scrolls the message right-to-left across the displays at a programmable step rate.
- Drives active-low 7-segment patterns (bit order g f e d c b a; 1 = off) straight to the board pins.

Parameters:
- STEP_DIV, 12500000: CLOCK_50 cycles per scroll step (4 Hz). Must be >= 1; a value of 1 steps every cycle.
- MSG_DEPTH, 16: message buffer depth in characters, power of two.
- NUM_DIGITS, 6: number of displays driven.

Ports:
- CLOCK_50, in, 1: sole clock.
- Reset_Scroll, in, 1: synchronous reset, active-high.
- Char_Valid, in, 1: a character is offered.
- Char_Ready, out, 1: controller can accept a character.
- Char_Code, in, 5: character code. 0x00-0x0F = hex 0-F; 0x10 = L; 0x11 = i; 0x12 = t; 0x13-0x1F = blank.
- Char_Last, in, 1: qualifies the transfer as the final character of the message.
- Msg_Clear, in, 1: single-cycle pulse that discards the message and returns to loading.
- Scroll_En, in, 1: enables the step prescaler.
- Busy, out, 1: a message is being displayed.
- Seg7_Bus, out, 42: digit k occupies bits [7k+6:7k]. Digit 0 is far right, digit 5 is far left.

Behaviour:
- Reset (sync, Reset_Scroll=1 at an edge):
  - state = LOAD; wr_ptr = 0; len = 0; offset = 0; prescaler = 0.
  - Char_Ready = 1; Busy = 0.
  - Seg7_Bus = all ones (all segments off).
  - Reset has priority over every other input. A reset mid-SHOW blanks all digits on the next cycle.
- State LOAD:
  - Char_Ready = 1, Busy = 0. Seg7_Bus holds its previous value (all blank after reset or clear).
  - Transfer occurs when Char_Valid & Char_Ready: buf[wr_ptr] <= Char_Code, then wr_ptr++.
  - A transfer with Char_Last=1, or with wr_ptr == MSG_DEPTH-1 (forced last), does the following:
    - len <= wr_ptr+1; offset <= 0; prescaler <= 0; next state = SHOW.
- State SHOW:
  - Char_Ready = 0 and Char_Valid is ignored. Busy = 1.
  - Virtual ring length is L = len + NUM_DIGITS: the message followed by NUM_DIGITS blanks.
  - For j = 0..NUM_DIGITS-1, digit (NUM_DIGITS-1-j) shows position p = (offset+j) mod L.
    - If p < len, the digit shows the encoding of buf[p]; otherwise it shows blank.
  - Prescaler:
    - Counts only while Scroll_En=1 and holds its value while Scroll_En=0.
    - At terminal count STEP_DIV-1, the prescaler returns to 0 and offset increments.
    - offset wraps from L-1 to 0.
  - Seg7_Bus is registered. It reflects the buffer and offset one cycle after they change.
- Latency:
  - Final character accepted at edge t -> state = SHOW at t+1 -> Seg7_Bus shows frame 0 at t+2.
  - Each step edge -> new frame one cycle later.
- Msg_Clear:
  - In any state, on the next edge: state = LOAD, wr_ptr = 0, len = 0, offset = 0, prescaler = 0, Seg7_Bus = all ones.
  - Msg_Clear has priority over a simultaneous transfer; that character is dropped.
- Widths:
  - wr_ptr and len: clog2(MSG_DEPTH)+1 bits.
  - offset: wide enough to hold MSG_DEPTH+NUM_DIGITS-1.
  - prescaler: clog2(STEP_DIV) bits, with a minimum of 1 bit.
  - The modulo is computed by compare-and-subtract, never with a divider.

Decomposition:
- Shared package seg7_pkg:
  - Segment constants SEG7_0..SEG7_F, SEG7_L, SEG7_i, SEG7_t, and SEG7_BLANK = 7'h7F.
  - Char code localparams CH_L = 0x10, CH_I = 0x11, CH_T = 0x12, CH_BLANK = 0x13.
  - Code width = 5.
- Sub-module seg7_char_enc: purely combinational, 5-bit code -> 7-bit active-low pattern, with a blank default. Instantiated once per digit.

Test Plan (STEP_DIV=4 unless noted):
1. Reset, no stimulus -> Seg7_Bus = 42'h3FF_FFFF_FFFF, Char_Ready=1, Busy=0.
2. Scroll_En=0; load codes 0x0E, 0x10, 0x11, 0x12, 0x0E with Last on the fifth character.
   - Two cycles after the last transfer, digits 5..0 = 0000110, 1000111, 1101111, 0000111, 0000110, 1111111.
   - Char_Ready=0, Busy=1. The frame stays fixed.
3. Same message with Scroll_En=1:
   - Every 4 cycles the frame shifts left by one (digit 5 shows L after the first step).
   - With L=11, frame 0 reappears exactly 44 cycles after the first frame.
   - Deasserting Scroll_En for 10 cycles mid-count delays all following steps by 10 cycles.
4. Load 16 codes 0x00..0x0F with Last never asserted -> forced last on the 16th transfer, len=16.
   - Frame 0 shows digits 5..0 = 0, 1, 2, 3, 4, 5. A 17th Char_Valid is not accepted.
5. In LOAD, assert Msg_Clear in the same cycle as a valid transfer -> character dropped, wr_ptr=0.
   - In SHOW, Msg_Clear -> all digits blank and Char_Ready=1 on the next cycle.
6. Assert Reset_Scroll for 1 cycle mid-SHOW with STEP_DIV=1 -> next cycle all blank, LOAD, Busy=0.
   - A new 1-character message (0x05 with Last) then shows digit 5 = 0010010 two cycles after its transfer.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the HEX-display message scroller: character codes,
// active-low segment patterns (bit order g f e d c b a) and controller states.
package seg7_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    localparam logic [CODE_W-1:0] CH_L     = 5'h10;
    localparam logic [CODE_W-1:0] CH_I     = 5'h11;
    localparam logic [CODE_W-1:0] CH_T     = 5'h12;
    localparam logic [CODE_W-1:0] CH_BLANK = 5'h13;

    localparam logic [SEG_W-1:0] SEG7_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG7_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG7_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG7_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG7_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG7_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG7_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG7_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG7_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG7_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG7_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG7_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG7_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG7_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG7_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG7_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG7_L     = 7'h47;
    localparam logic [SEG_W-1:0] SEG7_i     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG7_t     = 7'h07;
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SHOW = 1'b1
    } scroll_state_t;

endpackage

// File: rtl/seg7_char_enc.sv
// Character code to active-low 7-segment pattern; unknown codes render blank.
module seg7_char_enc
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SEG_W-1:0]  o_seg
);

    // Code lookup
    always_comb begin
        o_seg = SEG7_BLANK;
        case (i_code)
            5'h00:   o_seg = SEG7_0;
            5'h01:   o_seg = SEG7_1;
            5'h02:   o_seg = SEG7_2;
            5'h03:   o_seg = SEG7_3;
            5'h04:   o_seg = SEG7_4;
            5'h05:   o_seg = SEG7_5;
            5'h06:   o_seg = SEG7_6;
            5'h07:   o_seg = SEG7_7;
            5'h08:   o_seg = SEG7_8;
            5'h09:   o_seg = SEG7_9;
            5'h0A:   o_seg = SEG7_A;
            5'h0B:   o_seg = SEG7_B;
            5'h0C:   o_seg = SEG7_C;
            5'h0D:   o_seg = SEG7_D;
            5'h0E:   o_seg = SEG7_E;
            5'h0F:   o_seg = SEG7_F;
            CH_L:    o_seg = SEG7_L;
            CH_I:    o_seg = SEG7_i;
            CH_T:    o_seg = SEG7_t;
            default: o_seg = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Loads a character message over a valid/ready stream and scrolls it
// right-to-left across the HEX displays, followed by a gap of blank digits.
module seg7_scroll_ctrl
    import seg7_pkg::*;
#(
    parameter int STEP_DIV   = 12500000,
    parameter int MSG_DEPTH  = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                      CLOCK_50,
    input  logic                      Reset_Scroll,
    input  logic                      Char_Valid,
    output logic                      Char_Ready,
    input  logic [CODE_W-1:0]         Char_Code,
    input  logic                      Char_Last,
    input  logic                      Msg_Clear,
    input  logic                      Scroll_En,
    output logic                      Busy,
    output logic [SEG_W*NUM_DIGITS-1:0] Seg7_Bus
);

    localparam int AW       = $clog2(MSG_DEPTH);
    localparam int PW       = AW + 1;
    localparam int RING_MAX = MSG_DEPTH + NUM_DIGITS;
    localparam int OW       = $clog2(RING_MAX);
    localparam int SW       = $clog2(2 * RING_MAX);
    localparam int PSW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    scroll_state_t                    r_state;
    logic [PW-1:0]                    r_wr_ptr;
    logic [PW-1:0]                    r_len;
    logic [OW-1:0]                    r_off;
    logic [PSW-1:0]                   r_ps;
    logic [SEG_W*NUM_DIGITS-1:0]      r_seg;
    logic [CODE_W-1:0]                r_buf [MSG_DEPTH];

    logic                             w_xfer;
    logic                             w_last;
    logic                             w_ps_tc;
    logic [SW-1:0]                    w_ring_len;
    logic [SW-1:0]                    w_len_ext;
    logic [SEG_W*NUM_DIGITS-1:0]      w_frame;

    assign w_xfer     = Char_Valid && (r_state == ST_LOAD);
    assign w_last     = Char_Last || (r_wr_ptr == PW'(MSG_DEPTH - 1));
    assign w_ps_tc    = (r_ps == PSW'(STEP_DIV - 1));
    assign w_len_ext  = SW'(r_len);
    assign w_ring_len = w_len_ext + SW'(NUM_DIGITS);

    // offset+j never reaches twice the ring length, so one conditional subtract wraps it
    for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_digit
        logic [SW-1:0]     w_pos_raw;
        logic [SW-1:0]     w_pos;
        logic [CODE_W-1:0] w_code;

        assign w_pos_raw = SW'(r_off) + SW'(j);
        assign w_pos     = (w_pos_raw >= w_ring_len) ? (w_pos_raw - w_ring_len) : w_pos_raw;
        assign w_code    = (w_pos < w_len_ext) ? r_buf[w_pos[AW-1:0]] : CH_BLANK;

        seg7_char_enc u_enc (
            .i_code (w_code),
            .o_seg  (w_frame[SEG_W*(NUM_DIGITS-1-j) +: SEG_W])
        );
    end

    // Message buffer write port; a clear or reset in the same cycle drops the character
    always_ff @(posedge CLOCK_50) begin
        if (w_xfer && !Reset_Scroll && !Msg_Clear) begin
            r_buf[r_wr_ptr[AW-1:0]] <= Char_Code;
        end
    end

    // Load/show sequencer with step prescaler and registered display frame
    always_ff @(posedge CLOCK_50) begin
        if (Reset_Scroll || Msg_Clear) begin
            r_state  <= ST_LOAD;
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_off    <= '0;
            r_ps     <= '0;
            r_seg    <= '1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (Char_Valid) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (w_last) begin
                            r_len   <= r_wr_ptr + PW'(1);
                            r_off   <= '0;
                            r_ps    <= '0;
                            r_state <= ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    r_seg <= w_frame;
                    if (Scroll_En) begin
                        if (w_ps_tc) begin
                            r_ps <= '0;
                            if (SW'(r_off) == (w_ring_len - SW'(1))) begin
                                r_off <= '0;
                            end else begin
                                r_off <= r_off + OW'(1);
                            end
                        end else begin
                            r_ps <= r_ps + PSW'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_LOAD;
                    r_wr_ptr <= '0;
                    r_len    <= '0;
                    r_off    <= '0;
                    r_ps     <= '0;
                    r_seg    <= '1;
                end
            endcase
        end
    end

    assign Char_Ready = (r_state == ST_LOAD);
    assign Busy       = (r_state == ST_SHOW);
    assign Seg7_Bus   = r_seg;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Self-checking bench: a vector table for load/clear behaviour plus scoreboarded
// scroll sequences on a STEP_DIV=4 and a STEP_DIV=1 instance sharing stimulus.
module tb_seg7_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid, last, clr, sen;
    logic [4:0]  code;
    logic        rdy4, busy4, rdy1, busy1;
    logic [41:0] seg4, seg1;

    always #5 clk = ~clk;

    seg7_scroll_ctrl #(.STEP_DIV(4), .MSG_DEPTH(16), .NUM_DIGITS(6)) dut (
        .CLOCK_50(clk), .Reset_Scroll(rst), .Char_Valid(valid), .Char_Ready(rdy4),
        .Char_Code(code), .Char_Last(last), .Msg_Clear(clr), .Scroll_En(sen),
        .Busy(busy4), .Seg7_Bus(seg4)
    );

    seg7_scroll_ctrl #(.STEP_DIV(1), .MSG_DEPTH(16), .NUM_DIGITS(6)) dut1 (
        .CLOCK_50(clk), .Reset_Scroll(rst), .Char_Valid(valid), .Char_Ready(rdy1),
        .Char_Code(code), .Char_Last(last), .Msg_Clear(clr), .Scroll_En(sen),
        .Busy(busy1), .Seg7_Bus(seg1)
    );

    localparam logic [41:0] BLANK42 = {6{7'h7F}};
    localparam logic [41:0] F_ELITE = {7'h06, 7'h47, 7'h6F, 7'h07, 7'h06, 7'h7F};
    localparam logic [41:0] F_FIVE  = {7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [41:0] F_HEX0  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    typedef struct {
        int          cyc;
        logic [41:0] seg;
        logic        sel1;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        v;
        logic [4:0]  c;
        logic        l;
        logic        clr;
        logic        rdy;
        logic        busy;
        logic [41:0] seg;
    } vec_t;
    vec_t tbl[14];

    logic [4:0] m_msg [16];
    int         m_len;

    function automatic logic [6:0] enc(input logic [4:0] c);
        case (c)
            5'h00: return 7'b1000000;
            5'h01: return 7'b1111001;
            5'h02: return 7'b0100100;
            5'h03: return 7'b0110000;
            5'h04: return 7'b0011001;
            5'h05: return 7'b0010010;
            5'h06: return 7'b0000010;
            5'h07: return 7'b1111000;
            5'h08: return 7'b0000000;
            5'h09: return 7'b0010000;
            5'h0A: return 7'b0001000;
            5'h0B: return 7'b0000011;
            5'h0C: return 7'b1000110;
            5'h0D: return 7'b0100001;
            5'h0E: return 7'b0000110;
            5'h0F: return 7'b0001110;
            5'h10: return 7'b1000111;
            5'h11: return 7'b1101111;
            5'h12: return 7'b0000111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected frame: message plus six blanks laid out as a ring, read from 'off'
    function automatic logic [41:0] model_frame(input int off);
        logic [4:0]  ring [32];
        logic [41:0] f;
        int          rl;
        rl = m_len + 6;
        for (int i = 0; i < rl; i++) ring[i] = (i < m_len) ? m_msg[i] : 5'h13;
        f = '0;
        for (int j = 0; j < 6; j++) f[7*(5-j) +: 7] = enc(ring[(off + j) % rl]);
        return f;
    endfunction

    function automatic vec_t mk(input logic v, input logic [4:0] c, input logic l,
                                input logic cl, input logic r, input logic b,
                                input logic [41:0] s);
        vec_t x;
        x.v = v; x.c = c; x.l = l; x.clr = cl; x.rdy = r; x.busy = b; x.seg = s;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
            e = sbq.pop_front();
            if (e.cyc < cycle) begin
                checks++;
                failures++;
                $display("FAIL sb_stale: entry for cycle %0d seen at %0d", e.cyc, cycle);
            end else if (e.sel1) begin
                check("frame_div1", 64'(seg1), 64'(e.seg));
            end else begin
                check("frame_div4", 64'(seg4), 64'(e.seg));
            end
        end
    endtask

    task automatic load(input int n, input logic use_last);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            code  = m_msg[i];
            last  = use_last && (i == n - 1);
            step();
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Drive Scroll_En (low during the pause window) and push the frame each edge should produce
    task automatic scroll(input int div, input logic sel1, input int ncyc, input int p0, input int plen);
        int   cnt;
        exp_t e;
        cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            sen = !(k >= p0 && k < p0 + plen);
            if (sen) cnt++;
            e.cyc  = cycle + 2;
            e.seg  = model_frame((cnt / div) % (m_len + 6));
            e.sel1 = sel1;
            sbq.push_back(e);
            step();
        end
        sen = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; last = 1'b0; clr = 1'b0; sen = 1'b0; code = 5'h00;
        step();
        step();
        check("reset_seg",   64'(seg4),  64'(BLANK42));
        check("reset_ready", 64'(rdy4),  64'(1'b1));
        check("reset_busy",  64'(busy4), 64'(1'b0));
        rst = 1'b0;

        tbl[0]  = mk(1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, BLANK42);
        tbl[1]  = mk(1'b1, 5'h0E, 1'b0, 1'b0, 1'b1, 1'b0, BLANK42);
        tbl[2]  = mk(1'b1, 5'h10, 1'b0, 1'b0, 1'b1, 1'b0, BLANK42);
        tbl[3]  = mk(1'b1, 5'h11, 1'b0, 1'b0, 1'b1, 1'b0, BLANK42);
        tbl[4]  = mk(1'b1, 5'h12, 1'b0, 1'b0, 1'b1, 1'b0, BLANK42);
        tbl[5]  = mk(1'b1, 5'h0E, 1'b1, 1'b0, 1'b0, 1'b1, BLANK42);
        tbl[6]  = mk(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, F_ELITE);
        tbl[7]  = mk(1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 1'b1, F_ELITE);
        tbl[8]  = mk(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, F_ELITE);
        tbl[9]  = mk(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0, BLANK42);
        tbl[10] = mk(1'b1, 5'h07, 1'b0, 1'b1, 1'b1, 1'b0, BLANK42);
        tbl[11] = mk(1'b1, 5'h05, 1'b1, 1'b0, 1'b0, 1'b1, BLANK42);
        tbl[12] = mk(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, F_FIVE);
        tbl[13] = mk(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0, BLANK42);

        for (int i = 0; i < 14; i++) begin
            valid = tbl[i].v;
            code  = tbl[i].c;
            last  = tbl[i].l;
            clr   = tbl[i].clr;
            step();
            check($sformatf("tbl%0d_ready", i), 64'(rdy4),  64'(tbl[i].rdy));
            check($sformatf("tbl%0d_busy", i),  64'(busy4), 64'(tbl[i].busy));
            check($sformatf("tbl%0d_seg", i),   64'(seg4),  64'(tbl[i].seg));
        end
        valid = 1'b0; last = 1'b0; clr = 1'b0;

        // Scrolling at STEP_DIV=4 with a 10-cycle Scroll_En pause mid-count
        m_msg[0] = 5'h0E; m_msg[1] = 5'h10; m_msg[2] = 5'h11; m_msg[3] = 5'h12; m_msg[4] = 5'h0E;
        m_len = 5;
        load(5, 1'b1);
        scroll(4, 1'b0, 100, 50, 10);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clear_show_seg",   64'(seg4), 64'(BLANK42));
        check("clear_show_ready", 64'(rdy4), 64'(1'b1));

        // Forced last on the 16th character, then a refused 17th offer
        for (int i = 0; i < 16; i++) m_msg[i] = 5'(i);
        m_len = 16;
        load(16, 1'b0);
        check("forced_last_ready", 64'(rdy4),  64'(1'b0));
        check("forced_last_busy",  64'(busy4), 64'(1'b1));
        valid = 1'b1;
        code  = 5'h1F;
        step();
        valid = 1'b0;
        check("no_accept_17", 64'(rdy4), 64'(1'b0));
        check("hex_frame0",   64'(seg4), 64'(F_HEX0));
        scroll(1, 1'b1, 25, 0, 0);

        // Reset mid-SHOW on the every-cycle stepping instance
        sen = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_show_seg",   64'(seg1),  64'(BLANK42));
        check("rst_show_ready", 64'(rdy1),  64'(1'b1));
        check("rst_show_busy",  64'(busy1), 64'(1'b0));
        m_msg[0] = 5'h05;
        m_len = 1;
        load(1, 1'b1);
        check("one_char_pending", 64'(seg1), 64'(BLANK42));
        step();
        check("one_char_frame", 64'(seg1), 64'(F_FIVE));
        check("one_char_busy",  64'(busy1), 64'(1'b1));

        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover: %0d entries never compared", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
